// File: rtl/vector_division_unit_pkg.sv
// Shared types, widths and helpers for the vector integer divide/remainder unit.
package vector_division_unit_pkg;

  localparam int unsigned VLEN  = 128;
  localparam int unsigned ELEN  = 64;
  localparam int unsigned HALF  = ELEN / 2;
  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] VSEW_32B = 2'b10;
  localparam logic [1:0] VSEW_64B = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ITER,
    ST_FIXUP,
    ST_DONE
  } div_state_e;

  typedef struct packed {
    logic [1:0]      vsew;
    logic            is_signed;
    logic            want_rem;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vs1;
  } div_req_t;

  // Two's complement magnitude of an element held in the low bits of a lane.
  function automatic logic [ELEN-1:0] magnitude(input logic [ELEN-1:0] e, input logic neg,
                                                input logic width_32);
    if (width_32) return {{HALF{1'b0}}, (neg ? HALF'(-e[HALF-1:0]) : e[HALF-1:0])};
    return neg ? ELEN'(-e) : e;
  endfunction

  // Sign restore followed by the RISC-V divide-by-zero and overflow results.
  function automatic logic [ELEN-1:0] fix_result(
    input logic [ELEN-1:0] quo,
    input logic [ELEN-1:0] rem,
    input logic [ELEN-1:0] dividend,
    input logic            neg_q,
    input logic            neg_r,
    input logic            div_zero,
    input logic            overflow,
    input logic            want_rem,
    input logic            width_32
  );
    logic [ELEN-1:0] q;
    logic [ELEN-1:0] r;
    logic [ELEN-1:0] res;
    q = neg_q ? ELEN'(-quo) : quo;
    r = neg_r ? ELEN'(-rem) : rem;
    if (div_zero) begin
      q = '1;
      r = dividend;
    end
    if (overflow) begin
      q = dividend;
      r = '0;
    end
    res = want_rem ? r : q;
    if (width_32) res = {{HALF{1'b0}}, res[HALF-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/vector_division_unit_lane.sv
// One 64-bit radix-2 restoring divider lane; operands are unsigned magnitudes.
module vector_division_unit_lane
  import vector_division_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            width_32,
  input  logic [ELEN-1:0] dividend,
  input  logic [ELEN-1:0] divisor,
  input  logic            check_ovf,
  output logic [ELEN-1:0] quotient,
  output logic [ELEN-1:0] remainder,
  output logic            div_zero,
  output logic            overflow
);

  logic [ELEN-1:0] div_q;
  logic [ELEN-1:0] min_mag;
  logic            msb;
  logic [ELEN:0]   shifted;
  logic [ELEN:0]   diff;

  // In 32-bit mode the dividend sits in the low half, so bits leave from bit 31.
  assign min_mag = width_32 ? ELEN'(64'h0000_0000_8000_0000) : {1'b1, {(ELEN-1){1'b0}}};
  assign msb     = width_32 ? quotient[HALF-1] : quotient[ELEN-1];
  assign shifted = {remainder, msb};
  assign diff    = shifted - {1'b0, div_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      div_q     <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      div_q     <= divisor;
      div_zero  <= (divisor == '0);
      overflow  <= check_ovf && (divisor == ELEN'(1)) && (dividend == min_mag);
    end else if (step) begin
      if (!diff[ELEN]) begin
        remainder <= diff[ELEN-1:0];
        quotient  <= {quotient[ELEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[ELEN-1:0];
        quotient  <= {quotient[ELEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/vector_division_unit.sv
// Element-wise vdiv/vdivu/vrem/vremu on 128-bit vectors using four iterative lanes.
module vector_division_unit
  import vector_division_unit_pkg::*;
(
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            request_i,
  output logic            ready_o,
  input  logic [1:0]      vsew_i,
  input  logic            signed_i,
  input  logic            remainder_i,
  input  logic [VLEN-1:0] vs2_i,
  input  logic [VLEN-1:0] vs1_i,
  output logic [VLEN-1:0] vd_o,
  output logic            valid_o,
  input  logic            result_ready_i,
  output logic            busy_o
);

  div_state_e       state;
  div_req_t         req;
  logic [CNT_W-1:0] cnt;
  logic             sew64;
  logic             lane_start;
  logic             lane_step;
  logic [VLEN-1:0]  res_vec;

  logic [ELEN-1:0] a_raw    [LANES];
  logic [ELEN-1:0] b_raw    [LANES];
  logic [ELEN-1:0] lane_quo [LANES];
  logic [ELEN-1:0] lane_rem [LANES];
  logic [ELEN-1:0] lane_res [LANES];
  logic            lane_dz  [LANES];
  logic            lane_ovf [LANES];

  assign sew64      = (req.vsew == VSEW_64B);
  assign lane_start = (state == ST_SETUP);
  assign lane_step  = (state == ST_ITER);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic sign_a;
    logic sign_b;

    // Lanes 2-3 only carry SEW32 elements; in SEW64 they idle on zeros.
    if (i < 2) begin : g_wide
      assign a_raw[i] = sew64 ? req.vs2[64*i +: 64] : {{HALF{1'b0}}, req.vs2[32*i +: 32]};
      assign b_raw[i] = sew64 ? req.vs1[64*i +: 64] : {{HALF{1'b0}}, req.vs1[32*i +: 32]};
    end else begin : g_narrow
      assign a_raw[i] = sew64 ? '0 : {{HALF{1'b0}}, req.vs2[32*i +: 32]};
      assign b_raw[i] = sew64 ? '0 : {{HALF{1'b0}}, req.vs1[32*i +: 32]};
    end

    assign sign_a = req.is_signed && (sew64 ? a_raw[i][ELEN-1] : a_raw[i][HALF-1]);
    assign sign_b = req.is_signed && (sew64 ? b_raw[i][ELEN-1] : b_raw[i][HALF-1]);

    vector_division_unit_lane u_lane (
      .clk       (clock_i),
      .rst       (reset_i),
      .start     (lane_start),
      .step      (lane_step),
      .width_32  (!sew64),
      .dividend  (magnitude(a_raw[i], sign_a, !sew64)),
      .divisor   (magnitude(b_raw[i], sign_b, !sew64)),
      .check_ovf (sign_a && sign_b),
      .quotient  (lane_quo[i]),
      .remainder (lane_rem[i]),
      .div_zero  (lane_dz[i]),
      .overflow  (lane_ovf[i])
    );

    assign lane_res[i] = fix_result(lane_quo[i], lane_rem[i], a_raw[i], sign_a ^ sign_b,
                                    sign_a, lane_dz[i], lane_ovf[i], req.want_rem, !sew64);
  end

  always_comb begin
    res_vec = '0;
    if (sew64) begin
      res_vec = {lane_res[1], lane_res[0]};
    end else begin
      for (int i = 0; i < LANES; i++) res_vec[32*i +: 32] = lane_res[i][HALF-1:0];
    end
  end

  // Control FSM; ready_o/busy_o are registered alongside the state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      req     <= '0;
      cnt     <= '0;
      vd_o    <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request_i) begin
            req     <= '{vsew: vsew_i, is_signed: signed_i, want_rem: remainder_i,
                         vs2: vs2_i, vs1: vs1_i};
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            if (vsew_i == VSEW_32B || vsew_i == VSEW_64B) begin
              state <= ST_SETUP;
            end else begin
              vd_o  <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          cnt   <= sew64 ? CNT_W'(63) : CNT_W'(31);
          state <= ST_ITER;
        end
        ST_ITER: begin
          if (cnt == '0) state <= ST_FIXUP;
          else           cnt   <= CNT_W'(cnt - 1'b1);
        end
        ST_FIXUP: begin
          vd_o    <= res_vec;
          valid_o <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          // Unsupported-width ops arrive here with valid_o low and raise it one edge later.
          if (valid_o && result_ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            valid_o <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
